// File: rtl/srio_user_pkg.sv
// -----------------------------------------------------------------------------
// srio_user_pkg
// Shared definitions for the SRIO user-side NWRITE generator/checker pair:
//   - chk_state_t   : receive checker FSM encoding
//   - ERR_*         : bit positions inside the 4-bit error flag vector
//   - BEAT_CNT_W    : width of the per-packet beat counter (up to 32 beats)
//   - keep_for_rem  : expected tkeep of the last beat for a byte remainder
// -----------------------------------------------------------------------------
package srio_user_pkg;

    localparam int BEAT_CNT_W = 6;

    localparam int ERR_W     = 4;
    localparam int ERR_DATA  = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_KEEP  = 2;
    localparam int ERR_FRAME = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_STATUS = 2'd3
    } chk_state_t;

    // Bytes fill the beat from the MSB lane down, so a remainder of n bytes
    // expects the top n keep bits set; a remainder of 0 means a full beat.
    function automatic logic [7:0] keep_for_rem(input logic [2:0] rem);
        logic [7:0] keep;
        if (rem == 3'd0) begin
            keep = 8'hFF;
        end else begin
            keep = ~(8'hFF >> rem);
        end
        return keep;
    endfunction

endpackage

// File: rtl/nwr_pattern_cmp.sv
// -----------------------------------------------------------------------------
// nwr_pattern_cmp
// Expected-data tracker for the incrementing NWRITE payload pattern.
// The reference for the current beat is FIRST_VALUE on a packet's first beat
// and the stored expected value otherwise; every accepted beat stores
// reference + 1 (wrapping modulo 2^64).
// Ports:
//   log_clk, log_rst_n : clock, asynchronous active-low reset
//   i_first            : current beat is a packet's first beat
//   i_advance          : current beat is accepted and checked
//   i_data             : payload beat
//   o_mismatch         : payload differs from the reference (combinational)
// -----------------------------------------------------------------------------
module nwr_pattern_cmp
    import srio_user_pkg::*;
#(
    parameter logic [63:0] FIRST_VALUE = 64'h1
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic        i_first,
    input  logic        i_advance,
    input  logic [63:0] i_data,
    output logic        o_mismatch
);

    logic [63:0] r_expected;
    logic [63:0] w_ref;

    assign w_ref      = i_first ? FIRST_VALUE : r_expected;
    assign o_mismatch = (i_data != w_ref);

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_expected <= FIRST_VALUE;
        end else if (i_advance) begin
            // NOTE: clocked state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of process ordering.
            r_expected <= w_ref + 64'd1;
        end
    end

endmodule

// File: rtl/nwr_data_checker.sv
// -----------------------------------------------------------------------------
// nwr_data_checker
// Target-side checker for the NWRITE user payload stream. Verifies the
// incrementing data pattern, packet length, last-beat keep and first-beat
// framing; reports per-packet status, sticky error flags and saturating
// good/bad packet counters.
// Ports:
//   log_clk, log_rst_n      : clock, asynchronous active-low reset
//   user_tvalid_in/tready_o : beat handshake (tready low in STATUS/stall/reset)
//   user_tdata_in/tkeep_in  : payload beat and byte enables
//   user_tfirst_in/tlast_in : packet framing
//   user_tsize_in           : packet byte count minus 1 (first beat)
//   user_addr_in            : target address (first beat) -> last_addr_o
//   sink_stall_in           : backpressure injection
//   clear_in                : synchronous clear of counters and flags
//   pkt_done_o, pkt_ok_o    : one-cycle status pulse per finished packet
//   err_flags_o             : sticky {frame, keep, length, data}
//   pkt_cnt_o, err_cnt_o    : saturating good/bad packet counters
//   last_addr_o             : address of the most recent packet
// -----------------------------------------------------------------------------
module nwr_data_checker
    import srio_user_pkg::*;
#(
    parameter logic [63:0] FIRST_VALUE = 64'h1,
    parameter int unsigned MAX_BEATS   = 32
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic        user_tvalid_in,
    output logic        user_tready_o,
    input  logic [63:0] user_tdata_in,
    input  logic [7:0]  user_tkeep_in,
    input  logic        user_tfirst_in,
    input  logic        user_tlast_in,
    input  logic [19:0] user_tsize_in,
    input  logic [33:0] user_addr_in,
    input  logic        sink_stall_in,
    input  logic        clear_in,
    output logic        pkt_done_o,
    output logic        pkt_ok_o,
    output logic [3:0]  err_flags_o,
    output logic [15:0] pkt_cnt_o,
    output logic [15:0] err_cnt_o,
    output logic [33:0] last_addr_o
);

    chk_state_t              r_state;
    chk_state_t              w_next_state;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;
    logic [BEAT_CNT_W-1:0]   r_exp_beats;
    logic [7:0]              r_exp_keep;
    logic                    r_pkt_err;
    logic [ERR_W-1:0]        r_flags;
    logic [15:0]             r_pkt_cnt;
    logic [15:0]             r_err_cnt;
    logic [33:0]             r_last_addr;

    logic                    w_accept;
    logic                    w_mismatch;
    logic                    w_oversize;
    logic [BEAT_CNT_W-1:0]   w_first_beats;
    logic [BEAT_CNT_W-1:0]   w_beat_cnt_nxt;
    logic [7:0]              w_first_keep;
    logic [ERR_W-1:0]        w_err;
    logic                    w_pkt_start;
    logic                    w_cmp_adv;

    assign user_tready_o = log_rst_n && !sink_stall_in && (r_state != ST_STATUS);
    assign w_accept      = user_tvalid_in && user_tready_o;

    // Length decode of the first beat. (tsize+1+7)>>3 reduces to (tsize>>3)+1;
    // the truncation is safe because oversize packets never use this count.
    assign w_oversize     = ({1'b0, user_tsize_in} + 21'd1) > 21'(MAX_BEATS * 8);
    assign w_first_beats  = BEAT_CNT_W'(user_tsize_in >> 3) + BEAT_CNT_W'(1);
    assign w_first_keep   = keep_for_rem(user_tsize_in[2:0] + 3'd1);
    assign w_beat_cnt_nxt = r_beat_cnt + BEAT_CNT_W'(1);

    nwr_pattern_cmp #(
        .FIRST_VALUE (FIRST_VALUE)
    ) u_pattern_cmp (
        .log_clk    (log_clk),
        .log_rst_n  (log_rst_n),
        .i_first    (r_state == ST_IDLE),
        .i_advance  (w_cmp_adv),
        .i_data     (user_tdata_in),
        .o_mismatch (w_mismatch)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        w_next_state = r_state;
        w_err        = '0;
        w_pkt_start  = 1'b0;
        w_cmp_adv    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!user_tfirst_in) begin
                        // Stray beat outside a packet: flagged, never counted.
                        w_err[ERR_FRAME] = 1'b1;
                    end else begin
                        w_pkt_start    = 1'b1;
                        w_cmp_adv      = 1'b1;
                        w_err[ERR_DATA] = w_mismatch;
                        if (w_oversize) begin
                            w_err[ERR_LEN] = 1'b1;
                            w_next_state   = user_tlast_in ? ST_STATUS : ST_DRAIN;
                        end else if (user_tlast_in) begin
                            if (w_first_beats != BEAT_CNT_W'(1)) begin
                                w_err[ERR_LEN] = 1'b1;
                            end else begin
                                w_err[ERR_KEEP] = (user_tkeep_in != w_first_keep);
                            end
                            w_next_state = ST_STATUS;
                        end else if (w_first_beats == BEAT_CNT_W'(1)) begin
                            w_err[ERR_LEN] = 1'b1;
                            w_next_state   = ST_DRAIN;
                        end else begin
                            w_next_state = ST_RECV;
                        end
                    end
                end
            end

            ST_RECV: begin
                if (w_accept) begin
                    w_cmp_adv        = 1'b1;
                    w_err[ERR_DATA]  = w_mismatch;
                    w_err[ERR_FRAME] = user_tfirst_in;
                    if (user_tlast_in) begin
                        // Keep is only meaningful on the genuine last beat;
                        // an early tlast is already a length error.
                        if (w_beat_cnt_nxt != r_exp_beats) begin
                            w_err[ERR_LEN] = 1'b1;
                        end else begin
                            w_err[ERR_KEEP] = (user_tkeep_in != r_exp_keep);
                        end
                        w_next_state = ST_STATUS;
                    end else if (w_beat_cnt_nxt == r_exp_beats) begin
                        w_err[ERR_LEN] = 1'b1;
                        w_next_state   = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (w_accept && user_tlast_in) begin
                    w_next_state = ST_STATUS;
                end
            end

            ST_STATUS: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state and per-packet context.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_exp_beats <= '0;
            r_exp_keep  <= '0;
            r_pkt_err   <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pkt_start) begin
                r_beat_cnt  <= BEAT_CNT_W'(1);
                r_exp_beats <= w_first_beats;
                r_exp_keep  <= w_first_keep;
                r_last_addr <= user_addr_in;
                r_pkt_err   <= |w_err;
            end else if ((r_state == ST_RECV) && w_accept) begin
                r_beat_cnt <= w_beat_cnt_nxt;
                r_pkt_err  <= r_pkt_err | (|w_err);
            end
        end
    end

    // Sticky flags and saturating counters; clear_in overrides any update
    // in the same cycle, including the STATUS-cycle count.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_flags   <= '0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else if (clear_in) begin
            r_flags   <= '0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_flags <= r_flags | w_err;
            if (r_state == ST_STATUS) begin
                if (r_pkt_err) begin
                    if (r_err_cnt != 16'hFFFF) begin
                        r_err_cnt <= r_err_cnt + 16'd1;
                    end
                end else begin
                    if (r_pkt_cnt != 16'hFFFF) begin
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign pkt_done_o  = (r_state == ST_STATUS);
    assign pkt_ok_o    = (r_state == ST_STATUS) && !r_pkt_err;
    assign err_flags_o = r_flags;
    assign pkt_cnt_o   = r_pkt_cnt;
    assign err_cnt_o   = r_err_cnt;
    assign last_addr_o = r_last_addr;

endmodule

// File: tb/tb_nwr_data_checker.sv
// -----------------------------------------------------------------------------
// tb_nwr_data_checker
// Table-driven packet vectors with a scoreboard queue: each packet pushes its
// expected status when its last beat is driven; a monitor pops on pkt_done_o
// and compares status, sticky flags, address and counters. Hand-written
// sequences cover reset, reset mid-packet and a stray non-first beat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nwr_data_checker;

    logic        log_clk;
    logic        log_rst_n;
    logic        user_tvalid_in;
    logic        user_tready_o;
    logic [63:0] user_tdata_in;
    logic [7:0]  user_tkeep_in;
    logic        user_tfirst_in;
    logic        user_tlast_in;
    logic [19:0] user_tsize_in;
    logic [33:0] user_addr_in;
    logic        sink_stall_in;
    logic        clear_in;
    logic        pkt_done_o;
    logic        pkt_ok_o;
    logic [3:0]  err_flags_o;
    logic [15:0] pkt_cnt_o;
    logic [15:0] err_cnt_o;
    logic [33:0] last_addr_o;

    nwr_data_checker dut (
        .log_clk        (log_clk),
        .log_rst_n      (log_rst_n),
        .user_tvalid_in (user_tvalid_in),
        .user_tready_o  (user_tready_o),
        .user_tdata_in  (user_tdata_in),
        .user_tkeep_in  (user_tkeep_in),
        .user_tfirst_in (user_tfirst_in),
        .user_tlast_in  (user_tlast_in),
        .user_tsize_in  (user_tsize_in),
        .user_addr_in   (user_addr_in),
        .sink_stall_in  (sink_stall_in),
        .clear_in       (clear_in),
        .pkt_done_o     (pkt_done_o),
        .pkt_ok_o       (pkt_ok_o),
        .err_flags_o    (err_flags_o),
        .pkt_cnt_o      (pkt_cnt_o),
        .err_cnt_o      (err_cnt_o),
        .last_addr_o    (last_addr_o)
    );

    initial log_clk = 1'b0;
    always #5 log_clk = ~log_clk;

    int cyc = 0;
    always @(posedge log_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [19:0] tsize;
        int          nbeats;
        int          corrupt_idx;
        int          refirst_idx;
        logic [7:0]  last_keep;
        bit          stall;
        int          gap;
        bit          clear_status;
        bit          exp_ok;
        logic [3:0]  exp_err;
    } vec_t;

    typedef struct {
        bit          ok;
        logic [3:0]  err;
        logic [33:0] addr;
        int          done_cyc;
        bit          cleared;
    } exp_t;

    exp_t sb[$];

    // Reference model of sticky flags and counters.
    logic [3:0] m_flags = 4'h0;
    int         m_pkt   = 0;
    int         m_err   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge log_clk);
            user_tvalid_in = 1'b0;
            user_tfirst_in = 1'b0;
            user_tlast_in  = 1'b0;
            sink_stall_in  = 1'b0;
        end
    endtask

    // Drives nbeats beats of the pattern 1,2,3...; holds each beat until it is
    // accepted. Returns just before the accepting edge of the final beat.
    task automatic send_pkt(input logic [19:0] tsize, input int nbeats, input bit with_last,
                            input int corrupt_idx, input int refirst_idx,
                            input logic [7:0] last_keep, input bit stall_en,
                            input logic [33:0] addr,
                            output int first_acc, output int last_acc);
        bit acc;
        int tries;
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < nbeats; i++) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc) begin
                @(negedge log_clk);
                user_tvalid_in = 1'b1;
                user_tdata_in  = (i == corrupt_idx) ? 64'hDEAD : 64'(i + 1);
                user_tfirst_in = (i == 0) || (i == refirst_idx);
                user_tlast_in  = with_last && (i == nbeats - 1);
                user_tkeep_in  = (with_last && (i == nbeats - 1)) ? last_keep : 8'hFF;
                user_tsize_in  = tsize;
                user_addr_in   = addr;
                sink_stall_in  = stall_en && ($urandom_range(0, 2) == 0);
                #1;
                acc = user_tready_o;
                tries++;
                if (!acc && tries > 200) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_accept_timeout: beat %0d never accepted, want accept within 200 cycles", i);
                    return;
                end
            end
            if (i == 0) first_acc = cyc + 1;
            last_acc = cyc + 1;
        end
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge log_clk);
            if (pkt_done_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pkt_done: got pulse at cycle %0d, want none", cyc);
                end else begin
                    e = sb.pop_front();
                    m_flags = m_flags | e.err;
                    check("pkt_ok", pkt_ok_o, e.ok);
                    check("err_flags", err_flags_o, m_flags);
                    check("last_addr", last_addr_o, e.addr);
                    check("done_latency", cyc, e.done_cyc);
                    if (e.cleared) begin
                        m_flags = 4'h0;
                        m_pkt   = 0;
                        m_err   = 0;
                    end else if (e.ok) begin
                        m_pkt++;
                    end else begin
                        m_err++;
                    end
                    @(negedge log_clk);
                    check("done_pulse_width", pkt_done_o, 1'b0);
                    check("pkt_cnt", pkt_cnt_o, m_pkt);
                    check("err_cnt", err_cnt_o, m_err);
                    check("flags_after", err_flags_o, m_flags);
                end
            end
        end
    end

    initial begin
        vec_t        vecs[13];
        exp_t        e;
        int          first_acc;
        int          last_acc;
        int          prev_last;
        int          wait_cnt;
        logic [33:0] addr;

        //            tsize   nb  corr ref keep   stl gap clr ok  err
        vecs[0]  = '{20'd255, 32, -1, -1, 8'hFF, 0,  2,  0,  1, 4'h0};
        vecs[1]  = '{20'd36,   5, -1, -1, 8'hF8, 0,  0,  0,  1, 4'h0};
        vecs[2]  = '{20'd31,   4, -1, -1, 8'hFF, 0,  2,  0,  1, 4'h0};
        vecs[3]  = '{20'd31,   4,  2, -1, 8'hFF, 0,  2,  0,  0, 4'h1};
        vecs[4]  = '{20'd15,   2, -1, -1, 8'hFF, 0,  2,  0,  1, 4'h0};
        vecs[5]  = '{20'd31,   2, -1, -1, 8'hFF, 0,  2,  0,  0, 4'h2};
        vecs[6]  = '{20'd31,   5, -1, -1, 8'hFF, 0,  2,  0,  0, 4'h2};
        vecs[7]  = '{20'd36,   5, -1, -1, 8'hF8, 1,  2,  0,  1, 4'h0};
        vecs[8]  = '{20'd36,   5, -1, -1, 8'hF0, 1,  2,  1,  0, 4'h4};
        vecs[9]  = '{20'd7,    1, -1, -1, 8'hFF, 0,  2,  0,  1, 4'h0};
        vecs[10] = '{20'd0,    1, -1, -1, 8'h80, 0,  2,  0,  1, 4'h0};
        vecs[11] = '{20'd256, 33, -1, -1, 8'hFF, 0,  2,  0,  0, 4'h2};
        vecs[12] = '{20'd31,   4, -1,  1, 8'hFF, 0,  2,  0,  0, 4'h8};

        log_rst_n      = 1'b0;
        user_tvalid_in = 1'b0;
        user_tdata_in  = '0;
        user_tkeep_in  = '0;
        user_tfirst_in = 1'b0;
        user_tlast_in  = 1'b0;
        user_tsize_in  = '0;
        user_addr_in   = '0;
        sink_stall_in  = 1'b0;
        clear_in       = 1'b0;
        prev_last      = 0;

        repeat (3) @(negedge log_clk);
        check("rst_tready", user_tready_o, 1'b0);
        check("rst_pkt_done", pkt_done_o, 1'b0);
        check("rst_pkt_ok", pkt_ok_o, 1'b0);
        check("rst_flags", err_flags_o, 4'h0);
        check("rst_pkt_cnt", pkt_cnt_o, 16'h0);
        check("rst_err_cnt", err_cnt_o, 16'h0);
        check("rst_last_addr", last_addr_o, 34'h0);
        log_rst_n = 1'b1;
        #1;
        check("idle_tready", user_tready_o, 1'b1);

        for (int i = 0; i < 13; i++) begin
            addr = {2'($urandom_range(0, 3)), 32'($urandom)};
            send_pkt(vecs[i].tsize, vecs[i].nbeats, 1'b1, vecs[i].corrupt_idx,
                     vecs[i].refirst_idx, vecs[i].last_keep, vecs[i].stall, addr,
                     first_acc, last_acc);
            e = '{vecs[i].exp_ok, vecs[i].exp_err, addr, last_acc, vecs[i].clear_status};
            sb.push_back(e);
            if (i > 0 && vecs[i - 1].gap == 0) begin
                check("b2b_gap", first_acc - prev_last, 2);
            end
            prev_last = last_acc;
            if (vecs[i].clear_status) begin
                @(negedge log_clk);
                user_tvalid_in = 1'b0;
                sink_stall_in  = 1'b0;
                #1 clear_in = 1'b1;
                @(negedge log_clk);
                clear_in = 1'b0;
            end
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end

        // Reset in the middle of a 4-beat packet.
        idle(2);
        send_pkt(20'd31, 2, 1'b0, -1, -1, 8'hFF, 1'b0, 34'h1_2345_6789, first_acc, last_acc);
        @(negedge log_clk);
        user_tvalid_in = 1'b0;
        #1 log_rst_n = 1'b0;
        #1;
        check("midrst_tready", user_tready_o, 1'b0);
        check("midrst_pkt_done", pkt_done_o, 1'b0);
        check("midrst_flags", err_flags_o, 4'h0);
        check("midrst_pkt_cnt", pkt_cnt_o, 16'h0);
        check("midrst_err_cnt", err_cnt_o, 16'h0);
        check("midrst_last_addr", last_addr_o, 34'h0);
        m_flags = 4'h0;
        m_pkt   = 0;
        m_err   = 0;
        @(negedge log_clk);
        log_rst_n = 1'b1;

        // Stray non-first beat after reset.
        @(negedge log_clk);
        user_tvalid_in = 1'b1;
        user_tfirst_in = 1'b0;
        user_tlast_in  = 1'b1;
        user_tdata_in  = 64'h3;
        user_tkeep_in  = 8'hFF;
        #1;
        check("stray_tready", user_tready_o, 1'b1);
        @(negedge log_clk);
        user_tvalid_in = 1'b0;
        user_tlast_in  = 1'b0;
        m_flags = 4'h8;
        check("stray_flags", err_flags_o, m_flags);
        check("stray_pkt_cnt", pkt_cnt_o, 16'h0);
        check("stray_err_cnt", err_cnt_o, 16'h0);
        idle(3);

        // A good packet after the stray beat.
        addr = 34'h2_0000_0040;
        send_pkt(20'd15, 2, 1'b1, -1, -1, 8'hFF, 1'b0, addr, first_acc, last_acc);
        e = '{1'b1, 4'h0, addr, last_acc, 1'b0};
        sb.push_back(e);
        idle(4);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            @(negedge log_clk);
            wait_cnt++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge log_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
